gray_conv_sched: RTL
====================

# gray_conv_sched

Two-requester scheduler that shares one bit-serial Gray-to-binary conversion engine. Each requester presents a Gray code with a request/acknowledge handshake. A round-robin arbiter grants one request at a time. The engine converts the code MSB-first, one bit per cycle, and returns a registered binary result tagged with the requester id. It sits between the code-converter datapath and its clients, replacing per-client combinational converters with one time-shared engine.

## Interface
- WIDTH, 4, code width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request; held with g0 until ack0
- g0  input  WIDTH  requester 0 Gray code
- req1  input  1  requester 1 request; held with g1 until ack1
- g1  input  WIDTH  requester 1 Gray code
- ack0  output  1  one-cycle pulse: g0 captured
- ack1  output  1  one-cycle pulse: g1 captured
- busy  output  1  high while state ≠ IDLE
- res_valid  output  1  one-cycle pulse: res_bin/res_id valid
- res_id  output  1  id of requester owning res_bin
- res_bin  output  WIDTH  binary result, held until next result
- res_par  output  1  only with GCS_PARITY_EN: XOR-reduce of res_bin

## Operation
- Reset values (async, immediate): state=IDLE; ack0, ack1, busy, res_valid, res_id, res_bin, res_par all 0; round-robin pointer `last`=1, so req0 wins the first tie.
- IDLE: on an edge with any req high, grant:
  - If only one requester is asking, it wins.
  - If both are asking, the requester ≠ `last` wins.
  - At that edge: copy the winner's g into shift register `gs`, set `id`, set `last`=id, clear counter, and pulse ack(id) high for the next cycle. Next state is CONV.
- CONV, WIDTH edges, k = 0..WIDTH-1:
  - bit WIDTH-1-k is computed as b[i] = b[i+1] ^ g[i], with b[WIDTH] = 0 (b[WIDTH-1] = g[WIDTH-1]).
  - After the WIDTH-th edge, next state is DONE.
- DONE: one edge loads res_bin, res_id and res_par, pulses res_valid for one cycle, and returns to IDLE.
- Requests are not sampled outside IDLE. A requester whose req is still high in IDLE after its ack is treated as a new request.
- No request queue. A losing requester simply keeps req asserted.
- res_bin/res_id are stable between res_valid pulses.

## Timing
- Edge 0: capture; ack high in cycle 0→1.
- Edges 1..WIDTH: conversion.
- Edge WIDTH+1: res_valid high for one cycle; state=IDLE.
- Earliest next grant: edge WIDTH+2. Throughput is one conversion per WIDTH+2 cycles.
- Latency from capture edge to res_valid rising: WIDTH+1 cycles (5 for WIDTH=4).
- busy is high from capture edge +1 through the cycle containing edge WIDTH+1 (deasserts as state returns to IDLE).
- Requester must drop req at or before the edge where it samples ack high. It has until edge WIDTH+1 before a re-grant is possible.
- Simultaneous req0 and req1 in IDLE: winner alternates per `last`. Back-to-back contention gives strict 0,1,0,1 service.
- rst asserted mid-CONV or mid-DONE: in-flight conversion is discarded, no res_valid is produced, and all outputs and `last` return to reset values.

## Configuration
- GCS_PARITY_EN defined: res_par port exists and is registered with res_bin as ^res_bin; reset value 0.
- Undefined: no res_par port and no parity logic. All other behaviour is identical.

## Test plan
- Reset then req0=1, g0=0100 at edge 0 → ack0 pulse in cycle 0→1; res_valid at edge 5 with res_bin=0111, res_id=0; busy low after.
- req0 g0=1101 and req1 g1=1001 asserted together from reset → first result res_id=0, res_bin=1001; next grant at edge 6 to req1, res_bin=1110, res_id=1.
- Both requesters hold req continuously and re-present codes after each ack → grants alternate 0,1,0,1; no ack while busy.
- Assert rst at edge 2 of a conversion of g1=0011 → all outputs 0 immediately; no res_valid; next req0 wins even if req1 also high.
- WIDTH=8, g0=11111111 → res_bin=10101010 at edge 9; with GCS_PARITY_EN, res_par=0. With WIDTH=4, g0=0001 → res_bin=0001, res_par=1.
- req1 alone g1=0010, then res_bin held across 10 idle cycles → res_bin stays 0011, res_valid single-cycle.

Source files
------------

// File: rtl/gray_conv_sched.sv
// Two-requester round-robin scheduler sharing one bit-serial Gray-to-binary engine.
// Optional build macro GCS_PARITY_EN adds a registered res_par output (^res_bin).
module gray_conv_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] g0,
  input  logic             req1,
  input  logic [WIDTH-1:0] g1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_bin
`ifdef GCS_PARITY_EN
  ,
  output logic             res_par
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] gs;       // Gray code, consumed from the MSB end
  logic [WIDTH-1:0] bs;       // binary result, filled from the LSB end
  logic             b_prev;   // b[i+1] for the bit being computed
  logic [CW-1:0]    cnt;
  logic             id;
  logic             last;

  logic             grant_any;
  logic             grant_id;
  logic [WIDTH-1:0] grant_code;
  logic             b_next;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    grant_any  = req0 | req1;
    grant_id   = 1'b0;
    if (req0 && req1) begin
      grant_id = ~last;
    end else if (req1) begin
      grant_id = 1'b1;
    end
    grant_code = grant_id ? g1 : g0;
    b_next     = b_prev ^ gs[WIDTH-1];
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only; the small
  // datapath registers are reset too, so outputs are defined right after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gs        <= '0;
      bs        <= '0;
      b_prev    <= 1'b0;
      cnt       <= '0;
      id        <= 1'b0;
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_bin   <= '0;
`ifdef GCS_PARITY_EN
      res_par   <= 1'b0;
`endif
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            gs     <= grant_code;
            id     <= grant_id;
            last   <= grant_id;
            cnt    <= '0;
            b_prev <= 1'b0;
            ack0   <= ~grant_id;
            ack1   <= grant_id;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          b_prev <= b_next;
          bs     <= {bs[WIDTH-2:0], b_next};
          gs     <= {gs[WIDTH-2:0], 1'b0};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          res_bin   <= bs;
          res_id    <= id;
`ifdef GCS_PARITY_EN
          res_par   <= ^bs;
`endif
          res_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
